serial_subtractor: RTL

- Bit-serial N-bit subtractor computing DIFF = A - B, one bit per clock, LSB first.
- Uses a full-subtractor cell (difference plus borrow) and a registered borrow. It is the subtract-direction counterpart to the team's full-adder datapath.
- Sits in the arithmetic unit as a low-area subtract engine, driven by a START/BUSY/DONE handshake.

---
 rtl/serial_subtractor.sv | 106 ++++++++++
 1 files changed

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial A-B subtractor, LSB first, START/BUSY/DONE handshake
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_diff,
  output logic             o_borrow,
  output logic             o_ovf,
  output logic             o_busy,
  output logic             o_done
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_FINISH} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_r_sh;
  logic             r_br;
  logic [CW-1:0]    r_cnt;
  logic             r_a_msb;
  logic             r_b_msb;

  logic             w_d;
  logic             w_br_next;
  logic             w_last;
  logic [WIDTH-1:0] w_r_next;

  assign w_d       = r_a_sh[0] ^ r_b_sh[0] ^ r_br;
  assign w_br_next = (~r_a_sh[0] & r_b_sh[0]) | (~r_a_sh[0] & r_br) | (r_b_sh[0] & r_br);
  assign w_last    = (r_cnt == CW'(WIDTH - 1));

  // Difference bits enter at the MSB so the word is aligned after WIDTH shifts.
  generate
    if (WIDTH == 1) begin : g_r_one
      assign w_r_next = w_d;
    end else begin : g_r_wide
      assign w_r_next = {w_d, r_r_sh[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state  <= S_IDLE;
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_r_sh   <= '0;
      r_br     <= 1'b0;
      r_cnt    <= '0;
      r_a_msb  <= 1'b0;
      r_b_msb  <= 1'b0;
      o_diff   <= '0;
      o_borrow <= 1'b0;
      o_ovf    <= 1'b0;
      o_busy   <= 1'b0;
      o_done   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_FINISH: begin
          o_done <= 1'b0;
          if (i_start) begin
            r_a_sh  <= i_a;
            r_b_sh  <= i_b;
            r_a_msb <= i_a[WIDTH-1];
            r_b_msb <= i_b[WIDTH-1];
            r_br    <= 1'b0;
            r_r_sh  <= '0;
            r_cnt   <= '0;
            o_busy  <= 1'b1;
            r_state <= S_SHIFT;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_SHIFT: begin
          r_br   <= w_br_next;
          r_r_sh <= w_r_next;
          r_a_sh <= r_a_sh >> 1;
          r_b_sh <= r_b_sh >> 1;
          r_cnt  <= r_cnt + CW'(1);
          if (w_last) begin
            // The final difference bit is the result MSB used for overflow.
            o_diff   <= w_r_next;
            o_borrow <= w_br_next;
            o_ovf    <= (r_a_msb != r_b_msb) && (w_d != r_a_msb);
            o_done   <= 1'b1;
            o_busy   <= 1'b0;
            r_state  <= S_FINISH;
          end
        end
        default: begin
          o_busy  <= 1'b0;
          o_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
